// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, buffers responses for decode.
// Redirects flush the buffer and drain stale responses; optional FETCH_MISALIGN_EN traps misaligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PC_STEP    = 4,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fetch_misalign
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;
  logic [AW-1:0]   fl_wr, fl_rd;
  logic [AW-1:0]   fq_wr, fq_rd;
  logic [31:0]     fl_pc    [FIFO_DEPTH];
  logic [31:0]     fq_instr [FIFO_DEPTH];
  logic [31:0]     fq_pc    [FIFO_DEPTH];

  logic [CW:0]     occupancy;
  logic [CW-1:0]   next_drop;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic [31:0]     target_pc;
  logic            fetch_block;

`ifdef FETCH_MISALIGN_EN
  logic misalign;

  assign target_pc      = redirect_pc;
  assign fetch_block    = misalign;
  assign fetch_misalign = misalign;

  // Sticky until the next aligned redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign <= 1'b0;
    end else if (redirect_valid) begin
      misalign <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign target_pc      = redirect_pc & ~32'h3;
  assign fetch_block    = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  assign occupancy = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);

  assign imem_req_valid = !reset && (state == RUN) && !redirect_valid && !fetch_block && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response arriving alongside a redirect is stale as well.
  assign rsp_take  = imem_rsp_valid && (in_flight != '0);
  assign next_drop = in_flight - CW'(rsp_take);
  assign push      = rsp_take && !redirect_valid && (drop == '0);

  assign dec_valid = (fifo_count != '0);
  assign pop       = dec_valid && dec_ready && !redirect_valid;
  assign dec_instr = dec_valid ? fq_instr[fq_rd] : '0;
  assign dec_pc    = dec_valid ? fq_pc[fq_rd]    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      in_flight  <= '0;
      drop       <= '0;
      fifo_count <= '0;
      fl_wr      <= '0;
      fl_rd      <= '0;
      fq_wr      <= '0;
      fq_rd      <= '0;
    end else begin
      in_flight <= in_flight + CW'(req_fire) - CW'(rsp_take);
      if (req_fire) fl_wr <= fl_wr + AW'(1);
      if (rsp_take) fl_rd <= fl_rd + AW'(1);

      if (redirect_valid) begin
        pc         <= target_pc;
        drop       <= next_drop;
        state      <= (next_drop != '0) ? DRAIN : RUN;
        fifo_count <= '0;
        fq_rd      <= fq_wr;
      end else begin
        if (req_fire) pc <= pc + 32'(PC_STEP);
        if (rsp_take && (drop != '0)) begin
          drop <= drop - CW'(1);
          if (drop == CW'(1)) state <= RUN;
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (push) fq_wr <= fq_wr + AW'(1);
        if (pop)  fq_rd <= fq_rd + AW'(1);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire) fl_pc[fl_wr] <= pc;
    if (push) begin
      fq_instr[fq_wr] <= imem_rsp_data;
      fq_pc[fq_wr]    <= fl_pc[fl_rd];
    end
  end

endmodule
